// File: rtl/div_unit.sv
// div_unit: iterative 32-bit restoring divider for MIPS div/divu.
// A start pulse in IDLE captures the operands. Then 32 restoring steps run, one per cycle.
// A final FIX cycle applies the sign correction and the divide-by-zero override.
// Latency is fixed at 33 cycles from start to done for every operand.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    // state | meaning
    // IDLE  | waiting for start; results held
    // RUN   | one restoring step per cycle, counter 0..WIDTH-1
    // FIX   | sign correction / zero-divisor override, pulse done
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic capture;
    logic step;
    logic finish;

    // The partial remainder never reaches the divisor once a step has finished.
    // Its stored value therefore always fits in WIDTH bits.
    // The (WIDTH+1)-bit form exists only as rem_sh and trial inside a step.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             b_zero;
    logic [WIDTH-1:0] a_raw;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state datapath strobes
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_STEP) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand magnitudes for capture. For divu the raw values pass straight through.
    // |0x80000000| is 0x80000000 when read as unsigned, which the magnitude datapath expects.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (is_signed && a[WIDTH-1]) begin
            a_mag = -a;
        end
        if (is_signed && b[WIDTH-1]) begin
            b_mag = -b;
        end
    end

    // One restoring step: shift {rem, dq} left by one, then trial-subtract the divisor
    always_comb begin
        rem_sh = {rem, dq[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs};
    end

    // Final results: sign-correct the magnitudes; a zero divisor overrides both results
    always_comb begin
        q_fix = neg_q ? -dq : dq;
        r_fix = neg_r ? -rem : rem;
        if (b_zero) begin
            q_fix = {WIDTH{1'b1}};
            r_fix = a_raw;
        end
    end

    // Iteration registers: captured on start, updated once per RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem    <= '0;
            dq     <= '0;
            dvs    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= '0;
        end else if (capture) begin
            rem    <= '0;
            dq     <= a_mag;
            dvs    <= b_mag;
            cnt    <= '0;
            neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= is_signed & a[WIDTH-1];
            b_zero <= (b == '0);
            a_raw  <= a;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                dq  <= {dq[WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_sh[WIDTH-1:0];
                dq  <= {dq[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Registered outputs. Busy follows the next state, so it rises on the accepting edge.
    // Busy drops on the FIX edge, in the same cycle as done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= finish;
            if (finish) begin
                quotient    <= q_fix;
                remainder   <= r_fix;
                div_by_zero <= b_zero;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_cmp;
    int n_err;
    int lat;
    int busy_cnt;
    int done_after;

    div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one operation. Returns the edge index at which done is seen (-1 if it never is).
    // Also returns the number of sampled cycles with busy high, and done one cycle after completion.
    // When inj > 0, a second start with a=5, b=5 is presented so that it is sampled at edge inj.
    task automatic run_op(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                          input int inj, output int l, output int bc, output int da);
        l  = -1;
        bc = 0;
        da = 1;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        a         = av;
        b         = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy) bc++;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (inj > 0 && k == inj - 1) begin
                start = 1'b1;
                a     = 32'd5;
                b     = 32'd5;
            end else begin
                start = 1'b0;
            end
            if (busy) bc++;
            if (done) begin
                l = k;
                break;
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        da = int'(done);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // divu 100 / 7
        run_op(1'b0, 32'd100, 32'd7, 0, lat, busy_cnt, done_after);
        check("u100_7_lat", lat, 33);
        check("u100_7_busy", busy_cnt, 33);
        check("u100_7_q", quotient, 32'd14);
        check("u100_7_r", remainder, 32'd2);
        check("u100_7_dbz", {31'd0, div_by_zero}, 32'd0);
        check("u100_7_pulse", done_after, 0);

        // div -7 / 2
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, busy_cnt, done_after);
        check("s_m7_2_lat", lat, 33);
        check("s_m7_2_q", quotient, 32'hFFFF_FFFD);
        check("s_m7_2_r", remainder, 32'hFFFF_FFFF);

        // div 7 / -2: remainder takes the sign of the dividend
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, lat, busy_cnt, done_after);
        check("s_7_m2_q", quotient, 32'hFFFF_FFFD);
        check("s_7_m2_r", remainder, 32'd1);

        // div 0x80000000 / -1
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, busy_cnt, done_after);
        check("s_ovf_lat", lat, 33);
        check("s_ovf_q", quotient, 32'h8000_0000);
        check("s_ovf_r", remainder, 32'd0);
        check("s_ovf_dbz", {31'd0, div_by_zero}, 32'd0);

        // divu 0x80000000 / 0xFFFFFFFF
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, busy_cnt, done_after);
        check("u_big_q", quotient, 32'd0);
        check("u_big_r", remainder, 32'h8000_0000);

        // div 0 / -5
        run_op(1'b1, 32'd0, 32'hFFFF_FFFB, 0, lat, busy_cnt, done_after);
        check("s_zero_q", quotient, 32'd0);
        check("s_zero_r", remainder, 32'd0);

        // div by zero, then a normal divu clears the flag
        run_op(1'b1, 32'h1234_5678, 32'd0, 0, lat, busy_cnt, done_after);
        check("dbz_lat", lat, 33);
        check("dbz_q", quotient, 32'hFFFF_FFFF);
        check("dbz_r", remainder, 32'h1234_5678);
        check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
        run_op(1'b0, 32'd9, 32'd3, 0, lat, busy_cnt, done_after);
        check("u9_3_q", quotient, 32'd3);
        check("u9_3_r", remainder, 32'd0);
        check("u9_3_dbz", {31'd0, div_by_zero}, 32'd0);

        // signed negative dividend by zero: remainder is the raw dividend
        run_op(1'b1, 32'hFFFF_FF00, 32'd0, 0, lat, busy_cnt, done_after);
        check("dbz_neg_q", quotient, 32'hFFFF_FFFF);
        check("dbz_neg_r", remainder, 32'hFFFF_FF00);

        // divu 1000 / 10 with a second start sampled at E10
        run_op(1'b0, 32'd1000, 32'd10, 10, lat, busy_cnt, done_after);
        check("busy_start_lat", lat, 33);
        check("busy_start_q", quotient, 32'd100);
        check("busy_start_r", remainder, 32'd0);
        check("busy_start_pulse", done_after, 0);

        // divu 50 / 5 aborted by reset at E15
        @(negedge clk);
        start = 1'b1;
        a     = 32'd50;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_q", quotient, 32'd0);
        check("mid_rst_r", remainder, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_after = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_after = 1;
        end
        check("post_rst_quiet", done_after, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
